// File: rtl/css_mcu0_el2_pkg.sv
// rtl/css_mcu0_el2_pkg.sv - shared EL2 types for the LSU ECC write-back path
package css_mcu0_el2_pkg;

    localparam int EL2_DCCM_BITS = 16;
    localparam int EL2_DATA_W    = 32;
    localparam int EL2_ECC_W     = 7;

    typedef struct packed {
        logic                     lo_en;
        logic                     hi_en;
        logic [EL2_DCCM_BITS-1:0] addr_lo;
        logic [EL2_DCCM_BITS-1:0] addr_hi;
        logic [EL2_DATA_W-1:0]    data_lo;
        logic [EL2_DATA_W-1:0]    data_hi;
    } el2_ecc_wb_entry_t;

endpackage

// File: rtl/css_mcu0_rvecc_encode.sv
// rtl/css_mcu0_rvecc_encode.sv - 32-bit SECDED encoder (Hamming 38,32 plus overall parity)
module css_mcu0_rvecc_encode (
    input  logic [31:0] i_din,
    output logic [6:0]  o_ecc
);

    logic [5:0] w_hamming;
    logic [5:0] w_pos;

    // Data bits occupy codeword positions 3,5,6,7,9,... skipping the power-of-two check slots.
    always_comb begin
        w_hamming = '0;
        w_pos     = 6'd3;
        for (int i = 0; i < 32; i++) begin
            for (int k = 0; k < 6; k++) begin
                if (w_pos[k]) begin
                    w_hamming[k] = w_hamming[k] ^ i_din[i];
                end
            end
            w_pos = w_pos + 6'd1;
            if ((w_pos & (w_pos - 6'd1)) == 6'd0) begin
                w_pos = w_pos + 6'd1;
            end
        end
    end

    assign o_ecc = {(^i_din) ^ (^w_hamming), w_hamming};

endmodule

// File: rtl/css_mcu0_el2_lsu_ecc_wb.sv
// rtl/css_mcu0_el2_lsu_ecc_wb.sv - SEC scrub write-back queue with ECC error counters
module css_mcu0_el2_lsu_ecc_wb
    import css_mcu0_el2_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter int DCCM_BITS = EL2_DCCM_BITS,
    parameter int DATA_W    = EL2_DATA_W,
    parameter int ECC_W     = EL2_ECC_W,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_valid_r,
    input  logic                 flush_r,
    input  logic                 single_ecc_error_lo_r,
    input  logic                 single_ecc_error_hi_r,
    input  logic                 lsu_double_ecc_error_r,
    input  logic [DCCM_BITS-1:0] lsu_addr_r,
    input  logic [DCCM_BITS-1:0] end_addr_r,
    input  logic [DATA_W-1:0]    sec_data_lo_r,
    input  logic [DATA_W-1:0]    sec_data_hi_r,
    output logic                 wb_req,
    input  logic                 wb_gnt,
    output logic [DCCM_BITS-1:0] wb_addr_lo,
    output logic [DCCM_BITS-1:0] wb_addr_hi,
    output logic                 wb_wen_lo,
    output logic                 wb_wen_hi,
    output logic [DATA_W-1:0]    wb_data_lo,
    output logic [DATA_W-1:0]    wb_data_hi,
    output logic [ECC_W-1:0]     wb_ecc_lo,
    output logic [ECC_W-1:0]     wb_ecc_hi,
    output logic [CNT_W-1:0]     sec_cnt,
    output logic [CNT_W-1:0]     ded_cnt,
    output logic [DCCM_BITS-1:0] ded_addr,
    output logic                 ded_addr_vld,
    output logic                 wb_overflow,
    input  logic                 err_clr
);

    localparam int              PTR_W  = $clog2(DEPTH);
    localparam logic [PTR_W:0]  L_FULL = (PTR_W + 1)'(DEPTH);

    el2_ecc_wb_entry_t  r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic [CNT_W-1:0]   r_sec_cnt;
    logic [CNT_W-1:0]   r_ded_cnt;
    logic [DCCM_BITS-1:0] r_ded_addr;
    logic               r_ded_addr_vld;
    logic               r_overflow;

    logic               w_sec_any;
    logic               w_ded;
    logic               w_cap;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;
    el2_ecc_wb_entry_t  w_new;
    el2_ecc_wb_entry_t  w_head;

    assign w_sec_any = ld_valid_r & ~flush_r & (single_ecc_error_lo_r | single_ecc_error_hi_r);
    assign w_ded     = ld_valid_r & ~flush_r & lsu_double_ecc_error_r;
    // A DED in the same access means the corrected data cannot be trusted.
    assign w_cap     = w_sec_any & ~lsu_double_ecc_error_r;
    assign w_pop     = wb_req & wb_gnt;
    assign w_push    = w_cap & ((r_count != L_FULL) | w_pop);
    assign w_drop    = w_cap & ~w_push;

    assign w_new.lo_en   = single_ecc_error_lo_r;
    assign w_new.hi_en   = single_ecc_error_hi_r;
    assign w_new.addr_lo = lsu_addr_r;
    assign w_new.addr_hi = end_addr_r;
    assign w_new.data_lo = sec_data_lo_r;
    assign w_new.data_hi = sec_data_hi_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_new;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
                2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sec_cnt      <= '0;
            r_ded_cnt      <= '0;
            r_ded_addr     <= '0;
            r_ded_addr_vld <= 1'b0;
            r_overflow     <= 1'b0;
        end else if (err_clr) begin
            r_sec_cnt      <= '0;
            r_ded_cnt      <= '0;
            r_ded_addr     <= '0;
            r_ded_addr_vld <= 1'b0;
            r_overflow     <= 1'b0;
        end else begin
            if (w_sec_any && !(&r_sec_cnt)) begin
                r_sec_cnt <= r_sec_cnt + CNT_W'(1);
            end
            if (w_ded && !(&r_ded_cnt)) begin
                r_ded_cnt <= r_ded_cnt + CNT_W'(1);
            end
            if (w_ded && !r_ded_addr_vld) begin
                r_ded_addr     <= lsu_addr_r;
                r_ded_addr_vld <= 1'b1;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign w_head     = r_mem[r_rd_ptr];
    assign wb_req     = (r_count != '0);
    assign wb_addr_lo = w_head.addr_lo;
    assign wb_addr_hi = w_head.addr_hi;
    assign wb_wen_lo  = wb_req & w_head.lo_en;
    assign wb_wen_hi  = wb_req & w_head.hi_en;
    assign wb_data_lo = w_head.data_lo;
    assign wb_data_hi = w_head.data_hi;

    css_mcu0_rvecc_encode u_enc_lo (
        .i_din (w_head.data_lo),
        .o_ecc (wb_ecc_lo)
    );

    css_mcu0_rvecc_encode u_enc_hi (
        .i_din (w_head.data_hi),
        .o_ecc (wb_ecc_hi)
    );

    assign sec_cnt      = r_sec_cnt;
    assign ded_cnt      = r_ded_cnt;
    assign ded_addr     = r_ded_addr;
    assign ded_addr_vld = r_ded_addr_vld;
    assign wb_overflow  = r_overflow;

endmodule

// File: tb/tb_css_mcu0_el2_lsu_ecc_wb.sv
// tb/tb_css_mcu0_el2_lsu_ecc_wb.sv - randomized bench with queue-based reference model
module tb_css_mcu0_el2_lsu_ecc_wb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_valid_r, flush_r, single_ecc_error_lo_r, single_ecc_error_hi_r;
    logic        lsu_double_ecc_error_r, wb_gnt, err_clr;
    logic [15:0] lsu_addr_r, end_addr_r;
    logic [31:0] sec_data_lo_r, sec_data_hi_r;

    logic        wb_req, wb_wen_lo, wb_wen_hi, ded_addr_vld, wb_overflow;
    logic [15:0] wb_addr_lo, wb_addr_hi, sec_cnt, ded_cnt, ded_addr;
    logic [31:0] wb_data_lo, wb_data_hi;
    logic [6:0]  wb_ecc_lo, wb_ecc_hi;

    logic        s_req, s_wen_lo, s_wen_hi, s_dvld, s_ovf;
    logic [15:0] s_addr_lo, s_addr_hi, s_daddr;
    logic [31:0] s_data_lo, s_data_hi;
    logic [6:0]  s_ecc_lo, s_ecc_hi;
    logic [3:0]  s_sec_cnt, s_ded_cnt;

    always #5 clk = ~clk;

    css_mcu0_el2_lsu_ecc_wb #(.DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .ld_valid_r(ld_valid_r), .flush_r(flush_r),
        .single_ecc_error_lo_r(single_ecc_error_lo_r), .single_ecc_error_hi_r(single_ecc_error_hi_r),
        .lsu_double_ecc_error_r(lsu_double_ecc_error_r), .lsu_addr_r(lsu_addr_r), .end_addr_r(end_addr_r),
        .sec_data_lo_r(sec_data_lo_r), .sec_data_hi_r(sec_data_hi_r), .wb_req(wb_req), .wb_gnt(wb_gnt),
        .wb_addr_lo(wb_addr_lo), .wb_addr_hi(wb_addr_hi), .wb_wen_lo(wb_wen_lo), .wb_wen_hi(wb_wen_hi),
        .wb_data_lo(wb_data_lo), .wb_data_hi(wb_data_hi), .wb_ecc_lo(wb_ecc_lo), .wb_ecc_hi(wb_ecc_hi),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .ded_addr(ded_addr), .ded_addr_vld(ded_addr_vld),
        .wb_overflow(wb_overflow), .err_clr(err_clr)
    );

    // Narrow-counter copy so saturation is reached in a few cycles.
    css_mcu0_el2_lsu_ecc_wb #(.DEPTH(DEPTH), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .ld_valid_r(ld_valid_r), .flush_r(flush_r),
        .single_ecc_error_lo_r(single_ecc_error_lo_r), .single_ecc_error_hi_r(single_ecc_error_hi_r),
        .lsu_double_ecc_error_r(lsu_double_ecc_error_r), .lsu_addr_r(lsu_addr_r), .end_addr_r(end_addr_r),
        .sec_data_lo_r(sec_data_lo_r), .sec_data_hi_r(sec_data_hi_r), .wb_req(s_req), .wb_gnt(wb_gnt),
        .wb_addr_lo(s_addr_lo), .wb_addr_hi(s_addr_hi), .wb_wen_lo(s_wen_lo), .wb_wen_hi(s_wen_hi),
        .wb_data_lo(s_data_lo), .wb_data_hi(s_data_hi), .wb_ecc_lo(s_ecc_lo), .wb_ecc_hi(s_ecc_hi),
        .sec_cnt(s_sec_cnt), .ded_cnt(s_ded_cnt), .ded_addr(s_daddr), .ded_addr_vld(s_dvld),
        .wb_overflow(s_ovf), .err_clr(err_clr)
    );

    typedef struct packed {
        bit        lo_en;
        bit        hi_en;
        bit [15:0] addr_lo;
        bit [15:0] addr_hi;
        bit [31:0] data_lo;
        bit [31:0] data_hi;
    } m_entry_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // Codeword-position parity: data fills non-power-of-two slots 3..38.
    function automatic logic [6:0] ecc_ref(input logic [31:0] d);
        logic [38:1] cw;
        logic [6:0]  e;
        int          j;
        cw = '0;
        j  = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p] = d[j];
                j++;
            end
        end
        e = '0;
        for (int k = 0; k < 6; k++)
            for (int p = 1; p <= 38; p++)
                if (((p >> k) & 1) == 1) e[k] = e[k] ^ cw[p];
        e[6] = (^d) ^ (^e[5:0]);
        return e;
    endfunction

    function automatic longint sat(input longint n, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    m_entry_t    m_q[$];
    longint      m_sec, m_ded;
    bit          m_ovf, m_dvld;
    bit [15:0]   m_daddr;
    bit          mv_sec, mv_ded, mv_drop;
    m_entry_t    mv_e;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_sec = 0; m_ded = 0; m_ovf = 0; m_dvld = 0; m_daddr = '0;
        end else begin
            mv_sec  = ld_valid_r && !flush_r && (single_ecc_error_lo_r || single_ecc_error_hi_r);
            mv_ded  = ld_valid_r && !flush_r && lsu_double_ecc_error_r;
            mv_drop = 0;
            if (wb_gnt && m_q.size() > 0) void'(m_q.pop_front());
            if (mv_sec && !lsu_double_ecc_error_r) begin
                mv_e = '{single_ecc_error_lo_r, single_ecc_error_hi_r, lsu_addr_r, end_addr_r,
                         sec_data_lo_r, sec_data_hi_r};
                if (m_q.size() < DEPTH) m_q.push_back(mv_e);
                else mv_drop = 1;
            end
            if (err_clr) begin
                m_sec = 0; m_ded = 0; m_ovf = 0; m_dvld = 0; m_daddr = '0;
            end else begin
                if (mv_sec) m_sec++;
                if (mv_ded) m_ded++;
                if (mv_drop) m_ovf = 1;
                if (mv_ded && !m_dvld) begin
                    m_dvld  = 1;
                    m_daddr = lsu_addr_r;
                end
            end
        end
    end

    m_entry_t hd;
    always @(negedge clk) begin
        if (m_q.size() != 0) begin
            hd = m_q[0];
            chk("wb_req", wb_req, 1);
            chk("wb_wen_lo", wb_wen_lo, hd.lo_en);
            chk("wb_wen_hi", wb_wen_hi, hd.hi_en);
            chk("wb_addr_lo", wb_addr_lo, hd.addr_lo);
            chk("wb_addr_hi", wb_addr_hi, hd.addr_hi);
            chk("wb_data_lo", wb_data_lo, hd.data_lo);
            chk("wb_data_hi", wb_data_hi, hd.data_hi);
            chk("wb_ecc_lo", wb_ecc_lo, ecc_ref(hd.data_lo));
            chk("wb_ecc_hi", wb_ecc_hi, ecc_ref(hd.data_hi));
        end else begin
            chk("wb_req_idle", wb_req, 0);
            chk("wb_wen_lo_idle", wb_wen_lo, 0);
            chk("wb_wen_hi_idle", wb_wen_hi, 0);
        end
        chk("sec_cnt", sec_cnt, sat(m_sec, 16));
        chk("ded_cnt", ded_cnt, sat(m_ded, 16));
        chk("sec_cnt_w4", s_sec_cnt, sat(m_sec, 4));
        chk("ded_cnt_w4", s_ded_cnt, sat(m_ded, 4));
        chk("ded_addr_vld", ded_addr_vld, m_dvld);
        chk("ded_addr", ded_addr, m_daddr);
        chk("wb_overflow", wb_overflow, m_ovf);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clr_in();
        ld_valid_r = 0; flush_r = 0; single_ecc_error_lo_r = 0; single_ecc_error_hi_r = 0;
        lsu_double_ecc_error_r = 0; lsu_addr_r = '0; end_addr_r = '0;
        sec_data_lo_r = '0; sec_data_hi_r = '0; wb_gnt = 0; err_clr = 0;
    endtask

    task automatic sec_in(input bit lo, input bit hi, input logic [15:0] a, input logic [15:0] e,
                          input logic [31:0] dl, input logic [31:0] dh);
        ld_valid_r = 1; single_ecc_error_lo_r = lo; single_ecc_error_hi_r = hi;
        lsu_addr_r = a; end_addr_r = e; sec_data_lo_r = dl; sec_data_hi_r = dh;
    endtask

    task automatic drain_and_clear();
        clr_in(); wb_gnt = 1; tick(); tick(); tick();
        clr_in(); err_clr = 1; tick(); clr_in();
    endtask

    initial begin
        clr_in();
        tick(); tick();
        chk("reset_wb_req", wb_req, 0);
        chk("reset_sec_cnt", sec_cnt, 0);
        rst = 0;
        tick();

        sec_in(1, 0, 16'h0104, 16'h0107, 32'hDEADBEEF, 32'h12345678);
        tick(); clr_in();
        chk("lo_req", wb_req, 1);
        chk("lo_wen_lo", wb_wen_lo, 1);
        chk("lo_wen_hi", wb_wen_hi, 0);
        chk("lo_addr", wb_addr_lo, 16'h0104);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("lo_hold_req", wb_req, 1);
            chk("lo_hold_data", wb_data_lo, 32'hDEADBEEF);
        end
        wb_gnt = 1; tick(); wb_gnt = 0;
        chk("lo_after_gnt", wb_req, 0);
        err_clr = 1; tick(); clr_in();

        sec_in(1, 1, 16'h0106, 16'h0109, 32'h0000_0001, 32'h0000_0002);
        tick(); clr_in();
        chk("dual_wen_lo", wb_wen_lo, 1);
        chk("dual_wen_hi", wb_wen_hi, 1);
        chk("dual_addr_hi", wb_addr_hi, 16'h0109);
        chk("dual_sec_cnt", sec_cnt, 1);
        chk("ecc_lo_of_1", wb_ecc_lo, 7'h43);
        chk("ecc_hi_of_2", wb_ecc_hi, 7'h45);
        drain_and_clear();

        for (int i = 0; i < 3; i++) begin
            sec_in(1, 0, 16'h0010 + 16'(i), 16'h0013, 32'hA000_0000 + i, 32'h0);
            tick();
        end
        clr_in();
        chk("ovf_set", wb_overflow, 1);
        chk("ovf_sec_cnt", sec_cnt, 3);
        drain_and_clear();
        for (int i = 0; i < 3; i++) begin
            sec_in(0, 1, 16'h0020, 16'h0023 + 16'(i), 32'h0, 32'hB000_0000 + i);
            wb_gnt = (i == 2);
            tick();
        end
        clr_in();
        chk("no_ovf", wb_overflow, 0);
        chk("no_ovf_sec_cnt", sec_cnt, 3);
        chk("no_ovf_head", wb_data_hi, 32'hB000_0001);
        drain_and_clear();

        ld_valid_r = 1; lsu_double_ecc_error_r = 1; lsu_addr_r = 16'h0200; tick();
        lsu_addr_r = 16'h0300; single_ecc_error_lo_r = 1; tick(); clr_in();
        chk("ded_no_entry", wb_req, 0);
        chk("ded_cnt2", ded_cnt, 2);
        chk("ded_addr_first", ded_addr, 16'h0200);
        chk("ded_vld", ded_addr_vld, 1);
        err_clr = 1; tick(); clr_in();
        chk("clr_ded_cnt", ded_cnt, 0);
        chk("clr_ded_vld", ded_addr_vld, 0);
        chk("clr_sec_cnt", sec_cnt, 0);

        sec_in(1, 1, 16'h0400, 16'h0403, 32'h1, 32'h2); flush_r = 1; tick(); clr_in();
        chk("flush_no_req", wb_req, 0);
        chk("flush_no_cnt", sec_cnt, 0);
        for (int i = 0; i < 20; i++) begin
            sec_in(1, 0, 16'h0500 + 16'(i * 4), 16'h0503, $urandom, $urandom);
            wb_gnt = 1;
            tick();
        end
        clr_in();
        chk("sat_w4", s_sec_cnt, 4'hF);
        chk("sat_w16", sec_cnt, 20);
        drain_and_clear();

        sec_in(1, 0, 16'h0600, 16'h0603, 32'h11, 32'h0); tick();
        sec_in(0, 1, 16'h0604, 16'h0607, 32'h0, 32'h22); tick(); clr_in();
        chk("pre_rst_req", wb_req, 1);
        @(posedge clk); #2; rst = 1; #1;
        chk("async_rst_req", wb_req, 0);
        @(negedge clk); rst = 0; wb_gnt = 1;
        tick(); tick(); wb_gnt = 0;
        chk("post_rst_req", wb_req, 0);
        chk("post_rst_addr", wb_addr_lo, 0);
        chk("post_rst_data", wb_data_hi, 0);

        for (int i = 0; i < 3000; i++) begin
            ld_valid_r             = ($urandom_range(0, 9) < 7);
            flush_r                = ($urandom_range(0, 9) == 0);
            single_ecc_error_lo_r  = $urandom_range(0, 1);
            single_ecc_error_hi_r  = $urandom_range(0, 1);
            lsu_double_ecc_error_r = ($urandom_range(0, 9) == 0);
            lsu_addr_r             = 16'($urandom);
            end_addr_r             = 16'($urandom);
            sec_data_lo_r          = $urandom;
            sec_data_hi_r          = $urandom;
            wb_gnt                 = $urandom_range(0, 1);
            err_clr                = ($urandom_range(0, 49) == 0);
            tick();
        end
        clr_in();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
